// File: rtl/water_level_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : water_level_matrix_driver
// Function : Column-scanned LED matrix driver showing a tank border plus a
//            bottom-up fill bar. Critical-level blinking is built only when
//            WATER_LEVEL_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module water_level_matrix_driver #(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int LEVEL_W      = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  output logic [COLS-1:0]    col_sel,
  output logic [ROWS-1:0]    row,
  output logic               frame_start
);

  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W     = $clog2(COLS);
  localparam int FILL_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PROD_W    = LEVEL_W + FILL_W;
  localparam int MAX_LEVEL = (1 << LEVEL_W) - 1;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [COL_W-1:0]   col_idx_q, col_idx_d;
  logic [LEVEL_W-1:0] pending_q, pending_d;
  logic [LEVEL_W-1:0] disp_q, disp_d;
  logic [COLS-1:0]    col_sel_q, col_sel_d;
  logic [ROWS-1:0]    row_q, row_d;
  logic               frame_start_q, frame_start_d;

  logic               advance;
  logic               frame_end;
  logic               blink_phase;
  logic [PROD_W-1:0]  prod;
  logic [FILL_W-1:0]  fill;
  logic [ROWS-1:0]    fill_mask;
  logic               is_border;
  logic               blank;

  always_comb begin
    advance    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    frame_end  = advance && (col_idx_q == COL_W'(COLS - 1));
    scan_cnt_d = advance ? '0 : scan_cnt_q + 1'b1;
    col_idx_d  = col_idx_q;
    if (advance) begin
      col_idx_d = frame_end ? '0 : col_idx_q + 1'b1;
    end
    pending_d  = level_valid ? level : pending_q;
    // The image only changes at a frame boundary so a frame never tears.
    disp_d     = frame_end ? pending_q : disp_q;
  end

`ifdef WATER_LEVEL_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  // Floor-scaled fill height; row 0 is always lit so level 0 still shows a bar.
  always_comb begin
    prod      = PROD_W'(disp_q) * PROD_W'(ROWS - 1);
    fill      = FILL_W'(prod / PROD_W'(MAX_LEVEL));
    fill_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      fill_mask[r] = (FILL_W'(r) <= fill);
    end
    is_border     = (col_idx_q == '0) || (col_idx_q == COL_W'(COLS - 1));
    blank         = blink_phase && (disp_q == '0);
    col_sel_d     = COLS'(1) << col_idx_q;
    row_d         = is_border ? '1 : (blank ? '0 : fill_mask);
    frame_start_d = (col_idx_q == '0) && (scan_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      col_idx_q     <= '0;
      pending_q     <= '0;
      disp_q        <= '0;
      col_sel_q     <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      col_idx_q     <= col_idx_d;
      pending_q     <= pending_d;
      disp_q        <= disp_d;
      col_sel_q     <= col_sel_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col_sel     = col_sel_q;
  assign row         = row_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_water_level_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_water_level_matrix_driver
// Function : Randomised scoreboard bench for water_level_matrix_driver; the
//            reference model follows WATER_LEVEL_BLINK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_water_level_matrix_driver;

  localparam int ROWS         = 7;
  localparam int COLS         = 5;
  localparam int LEVEL_W      = 2;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = COLS * SCAN_DIV;
  localparam int MAX_LEVEL    = (1 << LEVEL_W) - 1;

  typedef struct packed {
    logic [COLS-1:0] c;
    logic [ROWS-1:0] r;
    logic            f;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [LEVEL_W-1:0] level = '0;
  logic               level_valid = 1'b0;
  logic [COLS-1:0]    col_sel;
  logic [ROWS-1:0]    row;
  logic               frame_start;

  water_level_matrix_driver #(
    .ROWS(ROWS), .COLS(COLS), .LEVEL_W(LEVEL_W),
    .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .level_valid(level_valid),
    .col_sel(col_sel), .row(row), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: position is derived from the count of scan edges since reset.
  int k_m      = 0;
  int pend_m   = 0;
  int disp_m   = 0;
  int fe_cnt_m = 0;

  task automatic step(input logic rst, input logic v, input int lv);
    exp_t e;
    int   col;
    int   fill;
    bit   phase;
    @(negedge clk);
    #1;
    reset       = rst;
    level_valid = v;
    level       = LEVEL_W'(lv);
    if (rst) begin
      e = '0;
      k_m = 0; pend_m = 0; disp_m = 0; fe_cnt_m = 0;
    end else begin
      col = (k_m / SCAN_DIV) % COLS;
`ifdef WATER_LEVEL_BLINK_EN
      phase = ((fe_cnt_m / BLINK_FRAMES) % 2) == 1;
`else
      phase = 1'b0;
`endif
      fill = disp_m * (ROWS - 1) / MAX_LEVEL;
      e.c = COLS'(1 << col);
      e.f = (k_m % FRAME) == 0;
      if (col == 0 || col == COLS - 1) e.r = '1;
      else if (phase && disp_m == 0)   e.r = '0;
      else                             e.r = ROWS'((1 << (fill + 1)) - 1);
      if ((k_m % FRAME) == FRAME - 1) begin
        disp_m   = pend_m;
        fe_cnt_m = fe_cnt_m + 1;
      end
      if (v) pend_m = lv;
      k_m = k_m + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks = checks + 1;
      if (col_sel !== mon_e.c) begin
        errors = errors + 1;
        $display("FAIL col_sel t=%0t got %b want %b", $time, col_sel, mon_e.c);
      end
      checks = checks + 1;
      if (row !== mon_e.r) begin
        errors = errors + 1;
        $display("FAIL row t=%0t got %h want %h", $time, row, mon_e.r);
      end
      checks = checks + 1;
      if (frame_start !== mon_e.f) begin
        errors = errors + 1;
        $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, mon_e.f);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    idle(27);
    // Mid-frame update must not tear the current frame.
    step(1'b0, 1'b1, 2);
    idle(45);
    step(1'b0, 1'b1, 3);
    idle(40);
    step(1'b0, 1'b1, 1);
    idle(40);
    // Valid landing exactly on frame_end.
    for (int i = 0; i < FRAME && (k_m % FRAME) != 6; i++) idle(1);
    step(1'b0, 1'b1, 3);
    for (int i = 0; i < FRAME && (k_m % FRAME) != FRAME - 1; i++) idle(1);
    step(1'b0, 1'b1, 1);
    idle(50);
    // Critical level held for several blink periods.
    step(1'b0, 1'b1, 0);
    idle(130);
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, MAX_LEVEL)));
    end
    step(1'b0, 1'b1, 2);
    idle(30);
    for (int i = 0; i < FRAME && ((k_m / SCAN_DIV) % COLS) != 3; i++) idle(1);
    idle(1);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(45);
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
